// File: rtl/osd_pkg.sv
// rtl/osd_pkg.sv - shared OSD types and width helpers
package osd_pkg;

    localparam int OSD_N_DEFAULT = 64;
    localparam int OSD_Q_DEFAULT = 6;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RANK = 2'd1,
        ST_DONE = 2'd2
    } osd_state_e;

    // Index width for an N-position codeword; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A Q-bit signed LLR has a (Q-1)-bit saturated magnitude.
    function automatic int mag_width(input int q);
        return q - 1;
    endfunction

endpackage

// File: rtl/reliability_sort_perm_rank_counter.sv
// rtl/reliability_sort_perm_rank_counter.sv - combinational rank of position k
module rank_counter #(
    parameter int N = 64,
    parameter int M = 5,
    parameter int W = 6
) (
    input  logic [N*M-1:0] mag_flat,
    input  logic [W-1:0]   k,
    output logic [W-1:0]   rank
);

    logic [M-1:0] mag_k;
    logic [N-1:0] beats;

    // One comparator per position: j outranks k if stronger, or equal with lower index.
    always_comb begin
        mag_k = mag_flat[k*M +: M];
        beats = '0;
        for (int j = 0; j < N; j++) begin
            if (mag_flat[j*M +: M] > mag_k) begin
                beats[j] = 1'b1;
            end else if ((mag_flat[j*M +: M] == mag_k) && (W'(j) < k)) begin
                beats[j] = 1'b1;
            end
        end
    end

    // Popcount of the comparator results; at most N-1 so it fits in W bits.
    always_comb begin
        rank = '0;
        for (int j = 0; j < N; j++) begin
            rank = rank + W'(beats[j]);
        end
    end

endmodule

// File: rtl/reliability_sort_perm.sv
// rtl/reliability_sort_perm.sv - serial LLR load, reliability sort, permutation output
module reliability_sort_perm
    import osd_pkg::*;
#(
    parameter int N = OSD_N_DEFAULT,
    parameter int Q = OSD_Q_DEFAULT,
    parameter int W = idx_width(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [Q-1:0] in_llr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        hard_flat,
    output logic [N*W-1:0]      lambda1_flat,
    output logic [N*W-1:0]      lambda1_inv_flat
);

    localparam int             M    = mag_width(Q);
    localparam logic [W-1:0]   LAST = W'(N - 1);

    osd_state_e       state;
    logic [W-1:0]     cnt;
    logic [N*M-1:0]   mag_mem;
    logic [N-1:0]     hard_mem;
    logic [N*W-1:0]   lam_work;
    logic [N*W-1:0]   lam_inv_work;
    logic [N*W-1:0]   lam_next;
    logic [N*W-1:0]   lam_inv_next;
    logic [Q-1:0]     neg_llr;
    logic [M-1:0]     in_mag;
    logic [W-1:0]     rank_k;

    // Saturated magnitude: the most negative code has no positive twin, so clamp it.
    always_comb begin
        neg_llr = -in_llr;
        if (in_llr == {1'b1, {(Q-1){1'b0}}}) begin
            in_mag = '1;
        end else if (in_llr[Q-1]) begin
            in_mag = neg_llr[M-1:0];
        end else begin
            in_mag = in_llr[M-1:0];
        end
    end

    rank_counter #(
        .N (N),
        .M (M),
        .W (W)
    ) u_rank_counter (
        .mag_flat (mag_mem),
        .k        (cnt),
        .rank     (rank_k)
    );

    // Working permutations with this cycle's entry applied; also feeds the final snapshot.
    always_comb begin
        lam_next                    = lam_work;
        lam_inv_next                = lam_inv_work;
        lam_next[rank_k*W +: W]     = cnt;
        lam_inv_next[cnt*W +: W]    = rank_k;
    end

    // Control FSM, sample storage, and output snapshot taken only when a frame completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_LOAD;
            cnt              <= '0;
            in_ready         <= 1'b0;
            out_valid        <= 1'b0;
            hard_flat        <= '0;
            lambda1_flat     <= '0;
            lambda1_inv_flat <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        mag_mem[cnt*M +: M] <= in_mag;
                        hard_mem[cnt]       <= in_llr[Q-1];
                        if (cnt == LAST) begin
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            state    <= ST_RANK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_RANK: begin
                    lam_work     <= lam_next;
                    lam_inv_work <= lam_inv_next;
                    if (cnt == LAST) begin
                        cnt              <= '0;
                        out_valid        <= 1'b1;
                        hard_flat        <= hard_mem;
                        lambda1_flat     <= lam_next;
                        lambda1_inv_flat <= lam_inv_next;
                        state            <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_LOAD;
                    end
                end
                default: begin
                    state    <= ST_LOAD;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
